// File: rtl/elbeth_definitions.sv
// Shared trap-controller encodings: FSM states, trap kinds and exception codes.
// Pure constants; no timing or flow control.
package elbeth_definitions;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DRAIN    = 3'd1;
    localparam logic [2:0] ST_SAVE     = 3'd2;
    localparam logic [2:0] ST_CAUSE    = 3'd3;
    localparam logic [2:0] ST_RESTORE  = 3'd4;
    localparam logic [2:0] ST_REDIRECT = 3'd5;

    localparam logic [1:0] KIND_EXC  = 2'd0;
    localparam logic [1:0] KIND_ERET = 2'd1;
    localparam logic [1:0] KIND_IRQ  = 2'd2;

    localparam logic [3:0] ECODE_ILLEGAL_INST = 4'd2;
    localparam logic [3:0] ECODE_ECALL_M      = 4'd11;
    localparam logic [3:0] ECODE_M_EXT_INT    = 4'd11;

    // mcause MSB flags an interrupt rather than a synchronous exception
    localparam int CAUSE_INT_BIT = 31;

endpackage

// File: rtl/elbeth_trap_ctrl_if.sv
// Pipeline/CSR-facing signal bundle of the trap controller.
// slave = the controller, master = the pipeline and CSR file around it.
interface elbeth_trap_ctrl_if #(
    parameter int XLEN = 32
);
    logic            id_valid;
    logic            id_except;
    logic [3:0]      id_except_src;
    logic            id_eret;
    logic [XLEN-1:0] id_pc;
    logic            irq;
    logic            csr_mie;
    logic [XLEN-1:0] csr_mtvec;
    logic [XLEN-1:0] csr_mepc;
    logic            ex_busy;
    logic            stall_if;
    logic            stall_id;
    logic            flush_id;
    logic            flush_if;
    logic            pc_redirect;
    logic [XLEN-1:0] pc_target;
    logic            csr_epc_we;
    logic [XLEN-1:0] csr_epc_wdata;
    logic            csr_cause_we;
    logic [XLEN-1:0] csr_cause_wdata;
    logic            prv_push;
    logic            prv_pop;
    logic            trap_busy;

    modport slave (
        input  id_valid, id_except, id_except_src, id_eret, id_pc, irq, csr_mie,
               csr_mtvec, csr_mepc, ex_busy,
        output stall_if, stall_id, flush_id, flush_if, pc_redirect, pc_target,
               csr_epc_we, csr_epc_wdata, csr_cause_we, csr_cause_wdata,
               prv_push, prv_pop, trap_busy
    );

    modport master (
        output id_valid, id_except, id_except_src, id_eret, id_pc, irq, csr_mie,
               csr_mtvec, csr_mepc, ex_busy,
        input  stall_if, stall_id, flush_id, flush_if, pc_redirect, pc_target,
               csr_epc_we, csr_epc_wdata, csr_cause_we, csr_cause_wdata,
               prv_push, prv_pop, trap_busy
    );
endinterface

// File: rtl/elbeth_trap_drain_cnt.sv
// Saturating 4-bit drain counter; done rises once MAX drain cycles have been spent.
// Registered count, combinational done; no backpressure.
module elbeth_trap_drain_cnt #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam logic [3:0] MAX_V = 4'(MAX);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != MAX_V))
            cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // The count reaches MAX on the edge that leaves DRAIN, so MAX cycles are spent there.
    assign done = (cnt_q >= (MAX_V - 4'd1));
endmodule

// File: rtl/elbeth_trap_ctrl.sv
// Trap/eret sequencer: drain EX, write mepc/mcause, push/pop privilege, redirect PC.
// Redirect 4 cycles after an exception (3 for eret) with EX idle; IF/ID held while busy.
module elbeth_trap_ctrl
    import elbeth_definitions::*;
#(
    parameter int XLEN      = 32,
    parameter int DRAIN_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    elbeth_trap_ctrl_if.slave bus
);
    logic [2:0]      state_q, state_d;
    logic [1:0]      kind_q, kind_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            trigger, cnt_clr, cnt_en, drain_done;

    // Gated with rst so every output is low while reset is held
    assign trigger = rst && (state_q == ST_IDLE) && bus.id_valid &&
                     (bus.id_except || bus.id_eret || (bus.irq && bus.csr_mie));

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        pc_d     = pc_q;
        cause_d  = cause_q;
        target_d = target_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        bus.stall_if        = trigger || (state_q != ST_IDLE);
        bus.stall_id        = trigger || (state_q != ST_IDLE);
        bus.trap_busy       = (state_q != ST_IDLE);
        bus.flush_id        = 1'b0;
        bus.flush_if        = 1'b0;
        bus.pc_redirect     = 1'b0;
        bus.pc_target       = '0;
        bus.csr_epc_we      = 1'b0;
        bus.csr_epc_wdata   = '0;
        bus.csr_cause_we    = 1'b0;
        bus.csr_cause_wdata = '0;
        bus.prv_push        = 1'b0;
        bus.prv_pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    bus.flush_id = 1'b1;
                    pc_d         = bus.id_pc;
                    cnt_clr      = 1'b1;
                    state_d      = ST_DRAIN;
                    cause_d      = '0;
                    if (bus.id_except) begin
                        kind_d       = KIND_EXC;
                        cause_d[3:0] = bus.id_except_src;
                    end else if (bus.id_eret) begin
                        kind_d = KIND_ERET;
                    end else begin
                        kind_d                 = KIND_IRQ;
                        cause_d[3:0]           = ECODE_M_EXT_INT;
                        cause_d[CAUSE_INT_BIT] = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                cnt_en = 1'b1;
                if (!bus.ex_busy || drain_done)
                    state_d = (kind_q == KIND_ERET) ? ST_RESTORE : ST_SAVE;
            end
            ST_SAVE: begin
                bus.csr_epc_we    = 1'b1;
                bus.csr_epc_wdata = pc_q;
                state_d           = ST_CAUSE;
            end
            ST_CAUSE: begin
                bus.csr_cause_we    = 1'b1;
                bus.csr_cause_wdata = cause_q;
                bus.prv_push        = 1'b1;
                target_d            = bus.csr_mtvec;
                state_d             = ST_REDIRECT;
            end
            ST_RESTORE: begin
                bus.prv_pop = 1'b1;
                target_d    = bus.csr_mepc;
                state_d     = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                bus.pc_redirect = 1'b1;
                bus.flush_if    = 1'b1;
                bus.flush_id    = 1'b1;
                bus.pc_target   = target_q;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            kind_q   <= KIND_EXC;
            pc_q     <= '0;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            pc_q     <= pc_d;
            cause_q  <= cause_d;
            target_q <= target_d;
        end
    end

    elbeth_trap_drain_cnt #(.MAX(DRAIN_MAX)) u_drain_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .done (drain_done)
    );
endmodule

// File: tb/tb_elbeth_trap_ctrl.sv
// Bench for elbeth_trap_ctrl: per-cycle comparison against a trap-sequence model,
// plus hand-computed checks of write values, cycle offsets and pulse counts.
module tb_elbeth_trap_ctrl;
    localparam logic [9:0] F_STALL_IF = 10'h200, F_STALL_ID = 10'h100, F_FLUSH_ID = 10'h080;
    localparam logic [9:0] F_FLUSH_IF = 10'h040, F_REDIR = 10'h020, F_EPC = 10'h010;
    localparam logic [9:0] F_CAUSE = 10'h008, F_PUSH = 10'h004, F_POP = 10'h002, F_BUSY = 10'h001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    elbeth_trap_ctrl_if #(.XLEN(32)) bus();

    elbeth_trap_ctrl #(.XLEN(32), .DRAIN_MAX(15)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int n_epc = 0, n_cause = 0, n_push = 0, n_pop = 0, n_redir = 0, n_busy = 0;
    int epc_cyc = -1, cause_cyc = -1, pop_cyc = -1, redir_cyc = -1;
    logic [31:0] epc_val = '0, cause_val = '0, redir_tgt = '0;
    int s_epc, s_cause, s_push, s_pop, s_redir, s_busy, t0;

    // Model: a trap is a drain phase of 1..15 cycles followed by a fixed step list
    int m_busy = 0, m_kind = 0, m_drain = 0, m_post = 0;
    logic [31:0] m_pc = '0, m_cause = '0, m_tgt = '0;

    function automatic logic [105:0] dut_out();
        return {bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_if, bus.pc_redirect,
                bus.csr_epc_we, bus.csr_cause_we, bus.prv_push, bus.prv_pop, bus.trap_busy,
                bus.pc_target, bus.csr_epc_wdata, bus.csr_cause_wdata};
    endfunction

    task automatic chk(input string name, input logic [105:0] act, input logic [105:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cycle_check();
        logic [9:0]  ef;
        logic [31:0] et, ee, ec;
        logic [105:0] act;
        ef = '0; et = '0; ee = '0; ec = '0;
        if (!rst) begin
            m_busy = 0;
        end else if (m_busy == 0) begin
            if (bus.id_valid && (bus.id_except || bus.id_eret || (bus.irq && bus.csr_mie))) begin
                ef = F_STALL_IF | F_STALL_ID | F_FLUSH_ID;
                m_busy = 1; m_drain = 0; m_post = -1; m_pc = bus.id_pc;
                if (bus.id_except) begin
                    m_kind = 0; m_cause = {28'h0, bus.id_except_src};
                end else if (bus.id_eret) begin
                    m_kind = 1;
                end else begin
                    m_kind = 2; m_cause = 32'h8000_000B;
                end
            end
        end else begin
            ef = F_STALL_IF | F_STALL_ID | F_BUSY;
            if (m_post < 0) begin
                m_drain++;
                if (!bus.ex_busy || m_drain == 15) m_post = 0;
            end else begin
                if (m_kind == 1 && m_post == 0) begin
                    ef |= F_POP; m_tgt = bus.csr_mepc;
                end else if (m_kind != 1 && m_post == 0) begin
                    ef |= F_EPC; ee = m_pc;
                end else if (m_kind != 1 && m_post == 1) begin
                    ef |= F_CAUSE | F_PUSH; ec = m_cause; m_tgt = bus.csr_mtvec;
                end else begin
                    ef |= F_REDIR | F_FLUSH_IF | F_FLUSH_ID; et = m_tgt; m_busy = 0;
                end
                m_post++;
            end
        end
        act = dut_out();
        chk($sformatf("cycle%0d_outputs", cyc), act, {ef, et, ee, ec});
        if (bus.csr_epc_we)   begin n_epc++;   epc_cyc = cyc;   epc_val = bus.csr_epc_wdata; end
        if (bus.csr_cause_we) begin n_cause++; cause_cyc = cyc; cause_val = bus.csr_cause_wdata; end
        if (bus.prv_push)     n_push++;
        if (bus.prv_pop)      begin n_pop++; pop_cyc = cyc; end
        if (bus.pc_redirect)  begin n_redir++; redir_cyc = cyc; redir_tgt = bus.pc_target; end
        if (bus.trap_busy)    n_busy++;
        cyc++;
    endtask

    task automatic go(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cycle_check();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        s_epc = n_epc; s_cause = n_cause; s_push = n_push;
        s_pop = n_pop; s_redir = n_redir; s_busy = n_busy; t0 = cyc;
    endtask

    task automatic clear_id();
        bus.id_valid = 1'b0; bus.id_except = 1'b0; bus.id_eret = 1'b0; bus.irq = 1'b0;
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        chk(name, 106'(act), 106'(exp));
    endtask

    initial begin
        clear_id();
        bus.id_except_src = '0; bus.id_pc = '0; bus.csr_mie = 1'b0;
        bus.csr_mtvec = '0; bus.csr_mepc = '0; bus.ex_busy = 1'b0;
        #2 rst = 1'b0;
        #1 chk("reset_outputs", dut_out(), '0);
        go(3);
        rst = 1'b1;
        go(2);

        // illegal instruction, EX idle
        bus.csr_mtvec = 32'h200; bus.id_pc = 32'h100; bus.id_except_src = 4'd2;
        snap(); bus.id_valid = 1'b1; bus.id_except = 1'b1;
        go(1); clear_id(); go(6);
        chk_int("exc_epc_cycle", epc_cyc, t0 + 2);
        chk("exc_epc_value", 106'(epc_val), 106'(32'h100));
        chk_int("exc_cause_cycle", cause_cyc, t0 + 3);
        chk("exc_cause_value", 106'(cause_val), 106'(32'h2));
        chk_int("exc_redir_cycle", redir_cyc, t0 + 4);
        chk("exc_redir_target", 106'(redir_tgt), 106'(32'h200));
        chk_int("exc_push_count", n_push - s_push, 1);

        // eret
        bus.csr_mepc = 32'h104;
        snap(); bus.id_valid = 1'b1; bus.id_eret = 1'b1;
        go(1); clear_id(); go(5);
        chk_int("eret_pop_cycle", pop_cyc, t0 + 2);
        chk_int("eret_redir_cycle", redir_cyc, t0 + 3);
        chk("eret_redir_target", 106'(redir_tgt), 106'(32'h104));
        chk_int("eret_csr_writes", (n_epc - s_epc) + (n_cause - s_cause), 0);

        // external interrupt, enabled then masked
        bus.id_pc = 32'h300; bus.csr_mie = 1'b1;
        snap(); bus.id_valid = 1'b1; bus.irq = 1'b1;
        go(1); clear_id(); go(6);
        chk("irq_cause_value", 106'(cause_val), 106'(32'h8000_000B));
        chk("irq_epc_value", 106'(epc_val), 106'(32'h300));
        chk_int("irq_redir_count", n_redir - s_redir, 1);
        bus.csr_mie = 1'b0; bus.id_pc = 32'h304;
        snap(); bus.id_valid = 1'b1; bus.irq = 1'b1;
        go(6); clear_id();
        chk_int("irq_masked_busy", n_busy - s_busy, 0);

        // nothing fires without id_valid
        bus.csr_mie = 1'b1;
        snap(); bus.id_except = 1'b1; bus.id_eret = 1'b1; bus.irq = 1'b1;
        go(5); clear_id();
        chk_int("novalid_busy", n_busy - s_busy, 0);

        // all three at once, held while busy: exception only, one redirect
        bus.id_pc = 32'h500; bus.id_except_src = 4'd11;
        snap(); bus.id_valid = 1'b1; bus.id_except = 1'b1; bus.id_eret = 1'b1; bus.irq = 1'b1;
        go(3); clear_id(); go(6);
        chk_int("prio_redir_count", n_redir - s_redir, 1);
        chk_int("prio_push_pop", (n_push - s_push) * 10 + (n_pop - s_pop), 10);
        chk("prio_cause_value", 106'(cause_val), 106'(32'hB));
        chk_int("prio_redir_cycle", redir_cyc, t0 + 4);

        // EX busy for 40 cycles: drain forced out after 15, mtvec sampled late
        bus.csr_mtvec = 32'h400; bus.ex_busy = 1'b1; bus.id_pc = 32'h600; bus.id_except_src = 4'd2;
        snap(); bus.id_valid = 1'b1; bus.id_except = 1'b1;
        go(1); clear_id(); go(9);
        bus.csr_mtvec = 32'h480;
        go(30);
        bus.ex_busy = 1'b0;
        go(3);
        chk_int("drain_epc_cycle", epc_cyc, t0 + 16);
        chk_int("drain_redir_cycle", redir_cyc, t0 + 18);
        chk("drain_redir_target", 106'(redir_tgt), 106'(32'h480));
        chk_int("drain_redir_count", n_redir - s_redir, 1);

        // reset asserted during CAUSE
        bus.csr_mtvec = 32'h200; bus.id_pc = 32'h700;
        snap(); bus.id_valid = 1'b1; bus.id_except = 1'b1;
        go(1); clear_id(); go(2);
        #1 rst = 1'b0;
        #1 chk("rst_mid_outputs", dut_out(), '0);
        go(2);
        rst = 1'b1;
        go(8);
        chk_int("rst_mid_redir_count", n_redir - s_redir, 0);
        chk_int("rst_mid_cause_count", n_cause - s_cause, 0);
        chk_int("rst_mid_epc_count", n_epc - s_epc, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
